// File: rtl/tt_alu_pkg.sv
// Shared types and constants for the TinyTapeout 4-bit ALU tile.
// Optional feature macro used by the top: ALU_FLAGS_EN.
package tt_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_CMP = 3'b111
    } opcode_e;

    // Bit positions of the status flags on uio_out
    localparam int FLAG_ZERO  = 4;
    localparam int FLAG_CARRY = 5;
    localparam int FLAG_DIVZ  = 6;
    localparam int FLAG_VALID = 7;

    localparam logic [7:0] DIVZ_RESULT = 8'hFF;

endpackage

// File: rtl/alu_div4.sv
// Combinational 4-bit unsigned restoring divider: a / b -> quotient, remainder.
// divz_o flags b == 0; quotient/remainder are then don't-care for the caller.
module alu_div4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [3:0] quot_o,
    output logic [3:0] rem_o,
    output logic       divz_o
);

    logic [4:0] partial;

    always_comb begin
        // NOTE: combinational logic uses blocking '=' so each loop step sees the
        // previous step's partial remainder; every output is defaulted first so
        // no latch is inferred.
        partial = '0;
        quot_o  = '0;
        for (int i = 3; i >= 0; i--) begin
            partial = {partial[3:0], a_i[i]};
            if (partial >= {1'b0, b_i}) begin
                partial   = partial - {1'b0, b_i};
                quot_o[i] = 1'b1;
            end
        end
        rem_o  = partial[3:0];
        divz_o = (b_i == 4'd0);
    end

endmodule

// File: rtl/tt_um_alf19185_alu.sv
// TinyTapeout 4-bit ALU tile: opcode mux plus registered result and flags.
// Define ALU_FLAGS_EN to drive status flags on uio_out[7:4]; otherwise uio is unused.
module tt_um_alf19185_alu
    import tt_alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [3:0] op_a;
    logic [3:0] op_b;
    opcode_e    opcode;

    logic [3:0] div_quot;
    logic [3:0] div_rem;
    logic       div_zero;

    logic [4:0] sum;
    logic [7:0] result_d;
    logic [7:0] result_q;
    logic       carry_d;
    logic       divz_d;

    logic       unused_uio_bits;

    assign op_a   = ui_in[3:0];
    assign op_b   = ui_in[7:4];
    assign opcode = opcode_e'(uio_in[2:0]);
    assign unused_uio_bits = ^uio_in[7:3];

    alu_div4 u_div (
        .a_i    (op_a),
        .b_i    (op_b),
        .quot_o (div_quot),
        .rem_o  (div_rem),
        .divz_o (div_zero)
    );

    assign sum = {1'b0, op_a} + {1'b0, op_b};

    always_comb begin
        result_d = '0;
        carry_d  = 1'b0;
        divz_d   = 1'b0;
        case (opcode)
            OP_ADD: begin
                result_d = {3'b000, sum};
                carry_d  = sum[4];
            end
            OP_SUB: begin
                result_d = {4'h0, op_a} - {4'h0, op_b};
                carry_d  = (op_a < op_b);
            end
            OP_MUL: result_d = {4'h0, op_a} * {4'h0, op_b};
            OP_DIV: begin
                result_d = div_zero ? DIVZ_RESULT : {div_rem, div_quot};
                divz_d   = div_zero;
            end
            OP_AND: result_d = {4'h0, op_a & op_b};
            OP_OR:  result_d = {4'h0, op_a | op_b};
            OP_XOR: result_d = {4'h0, op_a ^ op_b};
            OP_CMP: result_d = {5'b00000, op_a < op_b, op_a > op_b, op_a == op_b};
            default: result_d = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking '<=' with an asynchronous
    // active-low reset so rst_n clears the outputs without waiting for clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
        end else if (ena) begin
            result_q <= result_d;
        end
    end

    assign uo_out = result_q;

`ifdef ALU_FLAGS_EN
    logic [7:0] flags_d;
    logic [7:0] flags_q;

    // Flags are computed from result_d so they land on the same edge as uo_out
    always_comb begin
        flags_d             = '0;
        flags_d[FLAG_ZERO]  = (result_d == 8'h00);
        flags_d[FLAG_CARRY] = carry_d;
        flags_d[FLAG_DIVZ]  = divz_d;
        flags_d[FLAG_VALID] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else if (ena) begin
            flags_q <= flags_d;
        end
    end

    assign uio_out = flags_q;
    assign uio_oe  = 8'hF0;
`else
    logic unused_flags;

    assign unused_flags = ^{carry_d, divz_d};
    assign uio_out      = 8'h00;
    assign uio_oe       = 8'h00;
`endif

endmodule

// File: tb/tb_tt_um_alf19185_alu.sv
// Self-checking bench for tt_um_alf19185_alu: directed vectors plus random
// stimulus against an arithmetic reference model; honours ALU_FLAGS_EN.
module tb_tt_um_alf19185_alu;

`ifdef ALU_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks;
    int errors;

    // Reference state: what the tile should currently be presenting
    int exp_res;
    bit exp_carry;
    bit exp_divz;
    bit exp_valid;

    tt_um_alf19185_alu dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model(input int a, input int b, input int op,
                                  output int r, output bit c, output bit d);
        c = 1'b0;
        d = 1'b0;
        case (op)
            0: begin r = a + b; c = (r >= 16); end
            1: begin r = (a - b + 256) % 256; c = (a < b); end
            2: r = a * b;
            3: begin
                if (b == 0) begin r = 255; d = 1'b1; end
                else r = (a % b) * 16 + (a / b);
            end
            4: r = a & b;
            5: r = a | b;
            6: r = a ^ b;
            default: r = (a < b ? 4 : 0) + (a > b ? 2 : 0) + (a == b ? 1 : 0);
        endcase
    endfunction

    function automatic logic [7:0] exp_uio();
        if (!FLAGS_EN) return 8'h00;
        return {exp_valid, exp_divz, exp_carry, exp_res == 0, 4'h0};
    endfunction

    function automatic logic [7:0] exp_oe();
        return FLAGS_EN ? 8'hF0 : 8'h00;
    endfunction

    // Drive one cycle of stimulus, then advance the model when the tile is enabled
    task automatic drive(input logic [7:0] ui, input int op, input logic en);
        int  r;
        bit  c;
        bit  d;
        logic [4:0] junk;
        junk = 5'($urandom_range(0, 31));
        @(negedge clk);
        ui_in  = ui;
        uio_in = {junk, 3'(op)};
        ena    = en;
        @(posedge clk);
        #1;
        if (en) begin
            model(int'(ui[3:0]), int'(ui[7:4]), op, r, c, d);
            exp_res   = r;
            exp_carry = c;
            exp_divz  = d;
            exp_valid = 1'b1;
        end
    endtask

    task automatic test_reset();
        ena    = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        rst_n  = 1'b0;
        exp_res = 0; exp_carry = 0; exp_divz = 0; exp_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== exp_oe()) begin
            errors++;
            $display("FAIL reset: uo_out=%h uio_out=%h uio_oe=%h expected 00 00 %h",
                     uo_out, uio_out, uio_oe, exp_oe());
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(8'(i * 37 + 1), i, 1'b0);
            checks++;
            if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
                errors++;
                $display("FAIL reset_hold[%0d]: uo_out=%h uio_out=%h expected 00 00",
                         i, uo_out, uio_out);
            end
        end
    endtask

    task automatic test_directed();
        logic [7:0] vec_ui [10] = '{8'h0F, 8'hFF, 8'h1F, 8'h10, 8'h05,
                                    8'hFF, 8'h0A, 8'h3A, 8'h5A, 8'h33};
        int         vec_op [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 7, 6};
        logic [7:0] vec_res[10] = '{8'h0F, 8'h1E, 8'h0E, 8'hFF, 8'h00,
                                    8'hE1, 8'hFF, 8'h13, 8'h02, 8'h00};
        for (int i = 0; i < 10; i++) begin
            drive(vec_ui[i], vec_op[i], 1'b1);
            checks++;
            if (uo_out !== vec_res[i] || uio_out !== exp_uio()) begin
                errors++;
                $display("FAIL directed[%0d] ui=%h op=%0d: uo_out=%h uio_out=%h expected %h %h",
                         i, vec_ui[i], vec_op[i], uo_out, uio_out, vec_res[i], exp_uio());
            end
        end
    endtask

    task automatic test_hold_and_async_reset();
        drive(8'h5A, 7, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(8'(32'($urandom)), int'($urandom_range(0, 7)), 1'b0);
            checks++;
            if (uo_out !== 8'h02 || uio_out !== exp_uio()) begin
                errors++;
                $display("FAIL hold[%0d]: uo_out=%h uio_out=%h expected 02 %h",
                         i, uo_out, uio_out, exp_uio());
            end
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_res = 0; exp_carry = 0; exp_divz = 0; exp_valid = 0;
        checks++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== exp_oe()) begin
            errors++;
            $display("FAIL async_reset: uo_out=%h uio_out=%h uio_oe=%h expected 00 00 %h",
                     uo_out, uio_out, uio_oe, exp_oe());
        end
        #1;
        rst_n = 1'b1;
        drive(8'h21, 0, 1'b1);
        checks++;
        if (uo_out !== 8'h03 || uio_out !== exp_uio()) begin
            errors++;
            $display("FAIL after_reset: uo_out=%h uio_out=%h expected 03 %h",
                     uo_out, uio_out, exp_uio());
        end
    endtask

    task automatic test_random();
        logic [7:0] ui;
        int         op;
        logic       en;
        for (int i = 0; i < 300; i++) begin
            ui = 8'($urandom);
            op = int'($urandom_range(0, 7));
            en = ($urandom_range(0, 9) < 8);
            drive(ui, op, en);
            checks++;
            if (uo_out !== 8'(exp_res) || uio_out !== exp_uio() || uio_oe !== exp_oe()) begin
                errors++;
                $display("FAIL random[%0d] ui=%h op=%0d ena=%0d: uo_out=%h uio_out=%h expected %h %h",
                         i, ui, op, en, uo_out, uio_out, 8'(exp_res), exp_uio());
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_hold_and_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
